cache_data_ctrl: RTL

//  Direct-mapped, one-word-per-line, write-through cache controller; the initiator that drives the data RAM array.

---
 rtl/cache_data_ctrl_pkg.sv | 25 ++
 rtl/cache_data_ctrl_tag_array.sv | 48 ++++
 rtl/cache_data_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cache_data_ctrl_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped write-through cache controller.
package cache_data_ctrl_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int INDEX_W     = 6;
  localparam int TAG_W       = ADDR_W - INDEX_W - 2;
  localparam int CACHE_LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR
  } state_e;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:INDEX_W+2];
  endfunction

endpackage

// File: rtl/cache_data_ctrl_tag_array.sv
// Tag storage plus valid vector; the read port is registered so its output lines up with the data RAM.
module cache_data_ctrl_tag_array
  import cache_data_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o
);

  logic [TAG_W-1:0]       tag_mem [CACHE_LINES];
  logic [CACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]       rd_tag_q;
  logic                   rd_valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: the tag memory has no reset; an entry is only meaningful once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[wr_idx_i] <= wr_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rd_tag_q <= tag_mem[rd_idx_i];
    if (clear_i) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= valid_q[rd_idx_i];
    end
  end

  assign rd_tag_o   = rd_tag_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/cache_data_ctrl.sv
// Direct-mapped, one-word-per-line, write-through cache controller between the MEM stage and the memory bus.
module cache_data_ctrl
  import cache_data_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [DATA_W-1:0]  cpu_wdata_i,
  output logic               cpu_done_o,
  output logic [DATA_W-1:0]  cpu_rdata_o,
  input  logic               flush_i,
  output logic [INDEX_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0]  ram_wdata_o,
  output logic               ram_write_o,
  input  logic [DATA_W-1:0]  ram_rdata_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cpu_done_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [31:0]         hit_cnt_q;
  logic [31:0]         miss_cnt_q;

  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                hit;
  logic                accept;
  logic                tag_clear;

  // The completion cycle is skipped so a request still held high alongside cpu_done is not re-accepted.
  assign accept    = (state_q == IDLE) && !flush_i && cpu_req_i && !cpu_done_q;
  assign tag_clear = rst_i || ((state_q == IDLE) && flush_i);
  assign hit       = rd_valid && (rd_tag == get_tag(addr_q));

  assign ram_addr_o  = (state_q == IDLE) ? get_index(cpu_addr_i) : get_index(addr_q);
  assign ram_wdata_o = (state_q == MEM_RD) ? mem_rdata_i : wdata_q;
  // Gated by reset so an ack landing on the reset edge cannot commit a refill.
  assign ram_write_o = !rst_i && (((state_q == LOOKUP) && we_q) ||
                                  ((state_q == MEM_RD) && mem_ack_i));

  cache_data_ctrl_tag_array u_tag_array (
    .clk_i      (clk_i),
    .clear_i    (tag_clear),
    .rd_idx_i   (ram_addr_o),
    .we_i       (ram_write_o),
    .wr_idx_i   (get_index(addr_q)),
    .wr_tag_i   (get_tag(addr_q)),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= cpu_addr_i;
            we_q    <= cpu_we_i;
            wdata_q <= cpu_wdata_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
          if (we_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= MEM_WR;
          end else if (hit) begin
            cpu_rdata_q <= ram_rdata_i;
            cpu_done_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack_i) begin
            mem_req_q   <= 1'b0;
            cpu_rdata_q <= mem_rdata_i;
            cpu_done_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        MEM_WR: begin
          if (mem_ack_i) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_done_o  = cpu_done_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule
